// File: rtl/vmul_pkg.sv
// vmul_pkg: default sizes and record types shared by the multiplier-sharing controller
package vmul_pkg;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_W          = 6;
    localparam int DEF_MUL_LAT    = 2;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_IDW        = $clog2(DEF_NUM_REQ);
    typedef struct packed {
        logic               vld;
        logic [DEF_IDW-1:0] id;
    } tag_t;
    typedef struct packed {
        logic [2*DEF_W-1:0] p;
        logic [DEF_IDW-1:0] id;
    } rsp_t;
endpackage

// File: rtl/vmul_rsp_fifo.sv
// vmul_rsp_fifo: synchronous FIFO of products tagged with their requester ID
module vmul_rsp_fifo
    import vmul_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rsp_t          din,
    input  logic          pop,
    output rsp_t          dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    rsp_t mem [DEPTH];
    logic [PW-1:0] wr, rd;
    logic pop_ok;
    assign pop_ok = pop && !empty;
    // storage is cleared on reset so the head reads zero until the first push
    always_ff @(posedge clk) begin
        if (rst) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr      <= (wr == PW'(DEPTH - 1)) ? '0 : wr + 1'b1;
            end
            if (pop_ok) rd <= (rd == PW'(DEPTH - 1)) ? '0 : rd + 1'b1;
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end
    assign dout  = mem[rd];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/vmul_share_ctrl.sv
// vmul_share_ctrl: time-shares one pipelined multiplier among requesters with credit-protected result return
// Build option: define VMUL_FIXED_PRIO_EN for fixed lowest-index-wins arbitration instead of round-robin.
module vmul_share_ctrl
    import vmul_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int W          = DEF_W,
    parameter int MUL_LAT    = DEF_MUL_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int IDW        = DEF_IDW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [2*W-1:0]       mul_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*W-1:0]       rsp_data,
    output logic [IDW-1:0]       rsp_id
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic accept, gnt_vld, pop, push, fifo_full, fifo_empty;
    logic [IDW-1:0] gnt_id, base;
    logic [CW-1:0] fifo_count;
    int occ;
    tag_t iss_tag;
    tag_t pipe [MUL_LAT];
    rsp_t head;
`ifdef VMUL_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IDW-1:0] rr_ptr;
    assign base = rr_ptr;
    // move the search start just past each accepted requester
    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= '0;
        else if (accept) rr_ptr <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
`endif
    // first valid requester at or after base, wrapping around
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(base) + k) % NUM_REQ]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'((int'(base) + k) % NUM_REQ);
            end
        end
    end
    // every accepted-but-unpopped product must have a FIFO slot waiting for it
    always_comb begin
        occ = int'(fifo_count) + int'(iss_tag.vld);
        for (int k = 0; k < MUL_LAT; k++) occ += int'(pipe[k].vld);
    end
    assign pop       = rsp_valid && rsp_ready;
    assign accept    = !rst && gnt_vld && (occ - int'(pop) < FIFO_DEPTH);
    assign req_ready = accept ? NUM_REQ'(1) << gnt_id : '0;
    // operand/tag issue register, then a tag delay line matched to the multiplier latency
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a   <= '0;
            mul_b   <= '0;
            iss_tag <= '0;
            for (int k = 0; k < MUL_LAT; k++) pipe[k] <= '0;
        end else begin
            if (accept) begin
                mul_a <= req_a[gnt_id*W +: W];
                mul_b <= req_b[gnt_id*W +: W];
            end
            iss_tag <= '{vld: accept, id: gnt_id};
            pipe[0] <= iss_tag;
            for (int k = 1; k < MUL_LAT; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign push = pipe[MUL_LAT-1].vld;
    vmul_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (rsp_t'{p: mul_p, id: pipe[MUL_LAT-1].id}),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    assign rsp_valid = !fifo_empty;
    assign rsp_data  = head.p;
    assign rsp_id    = head.id;
    // the credit check makes a push into a full FIFO unreachable
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && fifo_full));
    end
endmodule

// File: tb/tb_vmul_share_ctrl.sv
// tb_vmul_share_ctrl: directed table, corner sequences and random traffic against a scoreboard model
module tb_vmul_share_ctrl;
    localparam int N = 4, W = 6, LAT = 2, D = 4;
    logic clk = 1'b0, rst = 1'b1, rsp_ready = 1'b1;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [W-1:0] opa [N], opb [N];
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0] mul_a, mul_b;
    logic [2*W-1:0] mul_p, rsp_data;
    logic [2*W-1:0] mp [LAT];
    logic rsp_valid;
    logic [1:0] rsp_id;
    int n_chk = 0, n_fail = 0, cyc = 0, rr = 0, base, m_w;
    logic m_pop;
    logic [N-1:0] m_exp, last_xfer = '0;
    typedef struct {int id; int p; int cyc;} exp_t;
    exp_t q[$];
    typedef struct {int id; int a; int b; int p;} vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    vmul_share_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = opa[i];
            req_b[i*W +: W] = opb[i];
        end
    end

    // behavioural shared multiplier: product appears LAT clocks after its operands
    always_ff @(posedge clk) begin
        mp[0] <= 12'(mul_a) * 12'(mul_b);
        for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
    end
    assign mul_p = mp[LAT-1];

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard: products owed in acceptance order; grant expected from the arbitration and credit rules
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            rr = 0;
            last_xfer = '0;
            chk("ready_in_reset", int'(req_ready), 0);
        end else begin
            m_pop = rsp_valid && rsp_ready;
`ifdef VMUL_FIXED_PRIO_EN
            base = 0;
`else
            base = rr;
`endif
            m_w = -1;
            for (int k = N - 1; k >= 0; k--) if (req_valid[(base + k) % N]) m_w = (base + k) % N;
            m_exp = (m_w >= 0 && q.size() - int'(m_pop) < D) ? N'(1) << m_w : '0;
            chk("req_ready", int'(req_ready), int'(m_exp));
            if (rsp_valid) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_spurious: got rsp_valid=1 id=%0d data=%0d, required rsp_valid=0 (t=%0t)", rsp_id, rsp_data, $time);
                end else if (m_pop) begin
                    chk("rsp_data", int'(rsp_data), q[0].p);
                    chk("rsp_id", int'(rsp_id), q[0].id);
                    chk("rsp_min_latency", int'(cyc - q[0].cyc >= LAT + 2), 1);
                    void'(q.pop_front());
                end
            end
            last_xfer = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (last_xfer[i]) begin
                    q.push_back('{id: i, p: int'(opa[i]) * int'(opb[i]), cyc: cyc});
                    rr = (i + 1) % N;
                end
            end
        end
    end

    function automatic logic [W-1:0] rnd();
        int r = $urandom_range(0, 7);
        return r == 0 ? 6'd63 : r == 1 ? 6'd0 : W'($urandom);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (last_xfer[i]) begin
                opa[i] = rnd();
                opb[i] = rnd();
            end
        end
    endtask

    function automatic int xfer_id();
        for (int i = 0; i < N; i++) if (last_xfer[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_mul_a", int'(mul_a), 0);
        chk("rst_mul_b", int'(mul_b), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic single_op(vec_t v);
        int t = 0;
        tick();
        opa[v.id] = W'(v.a);
        opb[v.id] = W'(v.b);
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        rsp_ready = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready[v.id] && t < 20);
        chk("single_accept", int'(req_ready[v.id]), 1);
        tick();
        req_valid = '0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("single_not_early", int'(rsp_valid), 0);
        @(negedge clk);
        chk("single_rsp_valid", int'(rsp_valid), 1);
        chk("single_rsp_data", int'(rsp_data), v.p);
        chk("single_rsp_id", int'(rsp_id), v.id);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, t, seen, g;
        tbl[0] = '{2, 5, 7, 35};
        tbl[1] = '{0, 63, 63, 3969};
        tbl[2] = '{1, 0, 45, 0};
        tbl[3] = '{3, 63, 1, 63};
        tbl[4] = '{2, 1, 63, 63};
        tbl[5] = '{1, 32, 32, 1024};
        tbl[6] = '{3, 7, 9, 63};
        tbl[7] = '{0, 45, 0, 0};
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        do_reset();
        foreach (tbl[i]) single_op(tbl[i]);

        // all requesters busy, free-flowing output: round-robin order and one result per clock
        do_reset();
        req_valid = '1;
        g = 0;
        for (int n = 1; n <= 24; n++) begin
            tick();
            refresh();
            if (last_xfer != '0) begin
                chk("rr_order", xfer_id(), g % N);
                g++;
            end
            if (n >= 5) chk("throughput", int'(rsp_valid), 1);
        end
        chk("rr_grants", g, 24);

        // output blocked: exactly FIFO_DEPTH accepts, then drain and resume
        do_reset();
        rsp_ready = 1'b0;
        req_valid = '1;
        acc = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            refresh();
            if (last_xfer != '0) acc++;
        end
        chk("blocked_accepts", acc, D);
        chk("blocked_ready", int'(req_ready), 0);
        rsp_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            refresh();
            chk("drain_valid", int'(rsp_valid), 1);
        end
        req_valid = '0;
        repeat (10) tick();
        chk("drained_valid", int'(rsp_valid), 0);
        chk("drained_sb", q.size(), 0);

        // reset with three products in flight and one queued
        do_reset();
        rsp_ready = 1'b0;
        req_valid = '1;
        acc = 0;
        t = 0;
        while (acc < 4 && t < 20) begin
            tick();
            refresh();
            if (last_xfer != '0) acc++;
            t++;
        end
        chk("inflight_setup", acc, 4);
        chk("inflight_fifo_one", int'(rsp_valid), 1);
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk("flush_rsp_valid", int'(rsp_valid), 0);
        chk("flush_req_ready", int'(req_ready), 0);
        seen = 0;
        repeat (6) begin
            tick();
            seen += int'(rsp_valid);
        end
        chk("flush_no_stale", seen, 0);

`ifdef VMUL_FIXED_PRIO_EN
        do_reset();
        req_valid = 4'b1010;
        for (int n = 0; n < 8; n++) begin
            tick();
            refresh();
            if (last_xfer != '0) chk("fixed_prio_low", int'(last_xfer), 2);
        end
        req_valid[1] = 1'b0;
        tick();
        chk("fixed_prio_next", int'(last_xfer), 8);
        req_valid = '0;
        repeat (8) tick();
`endif

        // random traffic with bursty backpressure and one mid-stream reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst = (n == 1500);
            for (int i = 0; i < N; i++) begin
                if (last_xfer[i] || !req_valid[i]) begin
                    req_valid[i] = $urandom_range(0, 3) != 0;
                    opa[i] = rnd();
                    opb[i] = rnd();
                end
            end
            rsp_ready = (n % 400 < 100) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (12) tick();
        chk("final_sb_empty", q.size(), 0);
        chk("final_rsp_valid", int'(rsp_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vmul_share_ctrl.md
Name: vmul_share_ctrl

Overview:
- Time-shares one pipelined 6x6 Vedic multiplier (fixed MUL_LAT register stages, no stall input) among NUM_REQ requesters.
- Arbitrates requests and registers the chosen operands onto the multiplier inputs.
- Tracks each in-flight product's requester ID in a tag pipeline.
- Returns products through a credit-protected result FIFO, so downstream backpressure never loses a result.
- Sits between FFT butterfly twiddle-multiply requesters and the shared multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- W, 6, operand width; product width is 2*W
- MUL_LAT, 2, multiplier latency in clocks from mul_a/mul_b to mul_p
- FIFO_DEPTH, 4, result FIFO entries; must be >= MUL_LAT+2
- IDW, 2, requester-ID width = clog2(NUM_REQ)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*W  packed operand A; slot i = [i*W +: W]
- req_b  in  NUM_REQ*W  packed operand B
- req_ready  out  NUM_REQ  one-hot-or-zero accept
- mul_a  out  W  operand A to multiplier (registered)
- mul_b  out  W  operand B to multiplier (registered)
- mul_p  in  2*W  product from multiplier
- rsp_valid  out  1  result available
- rsp_ready  in  1  downstream accepts result
- rsp_data  out  2*W  product
- rsp_id  out  IDW  requester that issued it

Behaviour:
- Reset: req_ready=0, mul_a=mul_b=0, rsp_valid=0, rsp_data=0, rsp_id=0. Issue valid, tag pipeline, FIFO pointers/count and RR pointer cleared. In-flight operations are discarded.
- Handshake: a transfer on requester i occurs when req_valid[i] && req_ready[i]. req_ready is asserted only for the granted requester. Requesters hold valid/operands until accepted.
- Arbitration: round-robin. Search starts at rr_ptr. After a grant to i, rr_ptr = i+1 mod NUM_REQ. rr_ptr is unchanged when there is no grant.
- Credit rule: occ = FIFO count + valid entries in the issue register and tag pipeline. pop = rsp_valid && rsp_ready. A grant is allowed only if occ - pop < FIFO_DEPTH. This is a combinational path from rsp_ready to req_ready (accepted).
- Issue: on an accept edge t, mul_a/mul_b/tag are loaded; the tag is {valid, id}. mul_a/mul_b hold their value when idle.
- Tag pipeline: a shift register of MUL_LAT stages, aligned so the tag exits in the cycle mul_p is valid (cycle t+1+MUL_LAT).
- Writeback: an exiting valid tag pushes {mul_p, id} into the FIFO. Push and pop in the same cycle are legal; the count is unchanged.
- Output: rsp_valid = FIFO non-empty; rsp_data/rsp_id come from the FIFO head (registered storage).
- Minimum latency, accept to rsp_valid: MUL_LAT+2 clocks (4 by default).
- Throughput: 1 result/clk sustained while rsp_ready=1.
- Overflow is impossible by the credit rule. Assertion: push when full is an error.
- Unsigned arithmetic only. 63*63 = 3969 fits in 12 bits; no truncation.
- rst mid-operation: everything is flushed next edge; no stale rsp_valid afterwards.

Optional Feature:
- Macro VMUL_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr logic is removed.
- Undefined (default): round-robin as above.
- Credit, tag and FIFO behaviour are identical in both cases.

Decomposition:
- Package vmul_pkg:
  - constants W, MUL_LAT, FIFO_DEPTH defaults
  - typedef tag_t {logic vld; logic [IDW-1:0] id}
  - typedef rsp_t {logic [2*W-1:0] p; logic [IDW-1:0] id}
- One natural sub-module: vmul_rsp_fifo, a synchronous FIFO of rsp_t with push/pop/count/full/empty.
- The arbiter stays inline.

Test Plan:
- After reset, only req_valid[2] with a=5, b=7 -> req_ready[2] for 1 cycle; rsp_valid 4 clks later with rsp_data=35, rsp_id=2.
- All 4 requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,...; one rsp per clk; IDs match the issue order.
- rsp_ready=0, all valid -> exactly FIFO_DEPTH accepts, then req_ready=0. Raise rsp_ready -> 4 results drain, then issue resumes with no loss or duplication.
- Operands a=63, b=63 -> rsp_data=3969. a=0, b=45 -> 0.
- Assert rst with 3 ops in flight and 1 in the FIFO -> next cycle rsp_valid=0, req_ready=0. No rsp emerges in the following 6 cycles without new requests.
- With VMUL_FIXED_PRIO_EN defined, req 1 and 3 always valid -> only 1 is granted while it stays valid; 3 is granted after 1 drops.
